// File: rtl/mux_8x1_pkg.sv
// Shared constants and types for the 8:1 lane selector.
package mux_8x1_pkg;

    localparam int NUM_LANES = 8;
    localparam int SEL_W     = 3;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_8x1_if.sv
// Bus bundle for mux_8x1: lanes, select and enable in; selected and captured values out.
// The chg signal exists only when MUX_8X1_CHG_DET_EN is defined.
interface mux_8x1_if
    import mux_8x1_pkg::*;
#(
    parameter int DATA_W = 1
);

    logic [NUM_LANES*DATA_W-1:0] in;
    sel_t                        sel;
    logic                        en;
    logic [DATA_W-1:0]           out;
    logic [DATA_W-1:0]           out_q;
    sel_t                        sel_q;
`ifdef MUX_8X1_CHG_DET_EN
    logic                        chg;
`endif

    modport master (
        output in, sel, en,
        input  out, out_q, sel_q
`ifdef MUX_8X1_CHG_DET_EN
        , input chg
`endif
    );

    modport slave (
        input  in, sel, en,
        output out, out_q, sel_q
`ifdef MUX_8X1_CHG_DET_EN
        , output chg
`endif
    );

endinterface

// File: rtl/mux_8x1_core.sv
// Purely combinational 8:1 lane selector; lane k sits at in[k*DATA_W +: DATA_W].
module mux_8x1_core
    import mux_8x1_pkg::*;
#(
    parameter int DATA_W = 1
)
(
    input  logic [NUM_LANES*DATA_W-1:0] in,
    input  sel_t                        sel,
    output logic [DATA_W-1:0]           out
);

    // Every select code maps to its lane; the case is complete, so no fallback is needed.
    always_comb begin
        case (sel)
            3'd0: out = in[0*DATA_W +: DATA_W];
            3'd1: out = in[1*DATA_W +: DATA_W];
            3'd2: out = in[2*DATA_W +: DATA_W];
            3'd3: out = in[3*DATA_W +: DATA_W];
            3'd4: out = in[4*DATA_W +: DATA_W];
            3'd5: out = in[5*DATA_W +: DATA_W];
            3'd6: out = in[6*DATA_W +: DATA_W];
            3'd7: out = in[7*DATA_W +: DATA_W];
        endcase
    end

endmodule

// File: rtl/mux_8x1.sv
// 8:1 lane selector with a combinational output and an enable-qualified registered copy.
// Optional feature: MUX_8X1_CHG_DET_EN adds a one-cycle chg pulse when a capture
// changes out_q (first capture after reset compares against 0).
module mux_8x1
    import mux_8x1_pkg::*;
#(
    parameter int DATA_W = 1
)
(
    input logic   clk,
    input logic   rst_n,
    mux_8x1_if.slave bus
);

    logic [DATA_W-1:0] out_c;
    logic [DATA_W-1:0] out_q_r;
    sel_t              sel_q_r;

    mux_8x1_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .in  (bus.in),
        .sel (bus.sel),
        .out (out_c)
    );

    // Capture the selected lane and its select code on enabled edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q_r <= '0;
            sel_q_r <= '0;
        end else if (bus.en) begin
            out_q_r <= out_c;
            sel_q_r <= bus.sel;
        end
    end

`ifdef MUX_8X1_CHG_DET_EN
    logic chg_r;

    // Pulse chg alongside a capture whose value differs from the held one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_r <= 1'b0;
        end else begin
            chg_r <= bus.en && (out_c != out_q_r);
        end
    end

    assign bus.chg = chg_r;
`endif

    assign bus.out   = out_c;
    assign bus.out_q = out_q_r;
    assign bus.sel_q = sel_q_r;

endmodule

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1: directed vector table, hand-written register/reset
// sequences, and randomized traffic against a shift-and-mask reference model.
module tb_mux_8x1;
    import mux_8x1_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_8x1_if #(.DATA_W(1)) bus1 ();
    mux_8x1_if #(.DATA_W(4)) bus4 ();

    mux_8x1 #(.DATA_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_8x1 #(.DATA_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic       q1_m;
    logic [2:0] sq1_m;
    logic       chg1_m;
    logic [3:0] q4_m;
    logic [2:0] sq4_m;
    logic       chg4_m;

    typedef struct {
        logic [7:0] in;
        logic [2:0] sel;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic ref1(logic [7:0] v, int s);
        return ((v >> s) & 8'h01) != 0;
    endfunction

    function automatic logic [3:0] ref4(logic [31:0] v, int s);
        logic [31:0] t;
        t = (v >> (4 * s)) & 32'h0000_000F;
        return t[3:0];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q1_m = 1'b0; sq1_m = 3'd0; chg1_m = 1'b0;
        q4_m = 4'h0; sq4_m = 3'd0; chg4_m = 1'b0;
    endtask

    // Advance one rising edge, updating the model from the values present at the edge.
    task automatic tick();
        logic       n1;
        logic [3:0] n4;
        @(posedge clk);
        if (bus1.en) begin
            n1 = ref1(bus1.in, int'(bus1.sel));
            chg1_m = (n1 != q1_m);
            q1_m = n1;
            sq1_m = bus1.sel;
        end else begin
            chg1_m = 1'b0;
        end
        if (bus4.en) begin
            n4 = ref4(bus4.in, int'(bus4.sel));
            chg4_m = (n4 != q4_m);
            q4_m = n4;
            sq4_m = bus4.sel;
        end else begin
            chg4_m = 1'b0;
        end
        #1;
    endtask

    task automatic check_regs(string tag);
        check({tag, ".out_q1"}, 32'(bus1.out_q), 32'(q1_m));
        check({tag, ".sel_q1"}, 32'(bus1.sel_q), 32'(sq1_m));
        check({tag, ".out_q4"}, 32'(bus4.out_q), 32'(q4_m));
        check({tag, ".sel_q4"}, 32'(bus4.sel_q), 32'(sq4_m));
`ifdef MUX_8X1_CHG_DET_EN
        check({tag, ".chg1"}, 32'(bus1.chg), 32'(chg1_m));
        check({tag, ".chg4"}, 32'(bus4.chg), 32'(chg4_m));
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        bus1.in = '0; bus1.sel = '0; bus1.en = 1'b0;
        bus4.in = '0; bus4.sel = '0; bus4.en = 1'b0;
        rst_n = 1'b0;
        #12;
        check_regs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // directed combinational vectors
        for (int k = 0; k < 8; k++) vecs.push_back('{in: 8'(1 << k), sel: 3'(k), exp: 1'b1});
        for (int k = 0; k < 8; k++) vecs.push_back('{in: 8'h00, sel: 3'(k), exp: 1'b0});
        vecs.push_back('{in: 8'b1111_1110, sel: 3'd0, exp: 1'b0});
        vecs.push_back('{in: 8'b0111_1111, sel: 3'd7, exp: 1'b0});
        vecs.push_back('{in: 8'b1010_0101, sel: 3'd5, exp: 1'b1});
        vecs.push_back('{in: 8'b1010_0101, sel: 3'd6, exp: 1'b0});
        foreach (vecs[i]) begin
            bus1.in  = vecs[i].in;
            bus1.sel = vecs[i].sel;
            #1;
            check($sformatf("vec%0d.out", i), 32'(bus1.out), 32'(vecs[i].exp));
        end

        // wide lanes
        bus4.in = 32'h7654_3210; bus4.sel = 3'd5;
        #1;
        check("w4.sel5", 32'(bus4.out), 32'h5);
        bus4.sel = 3'd7;
        #1;
        check("w4.sel7", 32'(bus4.out), 32'h7);

        // registered path and hold
        @(negedge clk);
        bus1.in = 8'b0000_0100; bus1.sel = 3'd2; bus1.en = 1'b1;
        tick();
        check("reg.out_q", 32'(bus1.out_q), 32'h1);
        check("reg.sel_q", 32'(bus1.sel_q), 32'h2);
        check_regs("reg");
        @(negedge clk);
        bus1.en = 1'b0; bus1.in = 8'h00;
        tick();
        check("hold.out_q", 32'(bus1.out_q), 32'h1);
        check("hold.out", 32'(bus1.out), 32'h0);
        check_regs("hold");

        // async reset between edges while out keeps tracking
        @(negedge clk);
        bus1.in = 8'b0000_0100;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst.out_q", 32'(bus1.out_q), 32'h0);
        check("arst.sel_q", 32'(bus1.sel_q), 32'h0);
        check("arst.out", 32'(bus1.out), 32'h1);
        bus1.sel = 3'd3;
        #1;
        check("arst.out_track", 32'(bus1.out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_regs("post_rst");

`ifdef MUX_8X1_CHG_DET_EN
        // captures 1, 1, 0 -> chg 1, 0, 1, then idle -> 0
        @(negedge clk);
        bus1.sel = 3'd0; bus1.in = 8'h01; bus1.en = 1'b1;
        tick();
        check("chg.a", 32'(bus1.chg), 32'h1);
        tick();
        check("chg.b", 32'(bus1.chg), 32'h0);
        @(negedge clk);
        bus1.in = 8'h00;
        tick();
        check("chg.c", 32'(bus1.chg), 32'h1);
        @(negedge clk);
        bus1.en = 1'b0; bus1.in = 8'h01;
        tick();
        check("chg.d", 32'(bus1.chg), 32'h0);
`endif

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            bus1.in  = 8'($urandom);
            bus1.sel = 3'($urandom_range(0, 7));
            bus1.en  = ($urandom_range(0, 3) != 0);
            bus4.in  = $urandom;
            bus4.sel = 3'($urandom_range(0, 7));
            bus4.en  = ($urandom_range(0, 2) != 0);
            #1;
            check("rnd.out1", 32'(bus1.out), 32'(ref1(bus1.in, int'(bus1.sel))));
            check("rnd.out4", 32'(bus4.out), 32'(ref4(bus4.in, int'(bus4.sel))));
            tick();
            check_regs("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_8x1.md
# mux_8x1

Eight-input, one-output selector with a combinational data path and an optional registered copy of the selected value. Used wherever one of eight equal-width lanes must be steered onto a single bus, e.g. status-bit selection or lane muxing ahead of a pipeline register. The combinational output carries no clock dependency. The registered output, clocked by `clk`, gives downstream logic a timing-clean version.

## Interface
- `DATA_W`, default 1: width of each input lane and of the outputs.
- `clk`  input  1  system clock, rising-edge active.
- `rst_n`  input  1  reset; one clock, asynchronous, active-low.
- `in`  input  8*DATA_W  packed lanes; lane k occupies bits `[k*DATA_W +: DATA_W]`.
- `sel`  input  3  lane select, 0..7.
- `en`  input  1  load enable for the registered output.
- `out`  output  DATA_W  combinational selected lane.
- `out_q`  output  DATA_W  registered selected lane.
- `sel_q`  output  3  select value captured with `out_q`.
- `chg`  output  1  change-detect pulse; present only with `MUX_8X1_CHG_DET_EN`.

## Operation
- `out = in[sel*DATA_W +: DATA_W]` for every `sel` value 0..7.
- All 8 codes are decoded, with no default or X branch.
- `out` depends only on `in` and `sel`; it is independent of `clk`, `rst_n` and `en`.
- On a rising `clk` with `en`=1:
  - `out_q` <= current `out`.
  - `sel_q` <= `sel`.
- With `en`=0, `out_q` and `sel_q` hold their values.
- Lanes not selected have no effect on any output.

## Timing
- `out`: zero-cycle latency. It settles within one combinational delay of any change on `in` or `sel`.
- `out_q`/`sel_q`: one-cycle latency from the `en`-qualified edge.
- Reset values: `out_q`=0, `sel_q`=0, `chg`=0. Reset takes effect immediately on `rst_n` falling, independent of `clk`.
- Reset deasserted: the first capture occurs on the first rising edge with `en`=1.
- Reset mid-operation:
  - Registered outputs clear at once.
  - `out` keeps following `in`/`sel`.
- If `in` or `sel` changes in the same cycle as a capture, the value present at the edge is captured.

## Configuration
- `MUX_8X1_CHG_DET_EN` defined:
  - Adds output `chg`.
  - `chg` is registered and is 1 for exactly one cycle after a capture in which the new `out_q` differs from the previous `out_q`. Otherwise it is 0.
  - The first capture after reset compares against the reset value 0.
- Undefined: the `chg` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `mux_8x1_pkg`:
  - `NUM_LANES` = 8.
  - `SEL_W` = 3.
  - Typedef `sel_t` (logic [SEL_W-1:0]).
- One sub-module is natural: `mux_8x1_core`, the purely combinational lane selector.
- The top level adds the capture register and the optional change detector.

## Test plan
- One-hot walk: for k = 0..7, `in` = 1<<k, `sel` = k -> `out` = 1. Then `in` = 0, same `sel` -> `out` = 0.
- Off-lane isolation: `in` = 8'b1111_1110, `sel` = 0 -> `out` = 0. `in` = 8'b0111_1111, `sel` = 7 -> `out` = 0.
- Registered path: `in` = 8'b0000_0100, `sel` = 2, `en` = 1, one rising edge -> `out_q` = 1, `sel_q` = 2. Then `en` = 0, `in` = 0 -> `out_q` stays 1 while `out` = 0.
- Async reset mid-operation: with `out_q` = 1, pulse `rst_n` low between clock edges -> `out_q` = 0 and `sel_q` = 0 immediately, while `out` still tracks `in`/`sel`.
- Change detect (macro on): captures of values 1, 1, 0 on consecutive enabled edges -> `chg` = 1, 0, 1.
- DATA_W = 4: `in` = 32'h7654_3210, `sel` = 5 -> `out` = 4'h5.
